// File: rtl/mont_reduce_iter_if.sv
// Operand/result handshake bundle for the iterative Montgomery reducer.
// Producer side drives operands and out_ready; engine side drives results.
interface mont_reduce_iter_if #(
  parameter int SIZE   = 3072,
  parameter int RADIX  = 78,
  parameter int ROUNDS = 40,
  parameter int RW     = 6
);
  localparam int AW = SIZE + RADIX * ROUNDS;

  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    a;
  logic [SIZE-1:0]  m;
  logic [RADIX-1:0] m_prime;
  logic [RW-1:0]    rounds_in;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  new_a;
  logic             out_ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output m,
    output m_prime,
    output rounds_in,
    input  out_valid,
    output out_ready,
    input  new_a,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  m,
    input  m_prime,
    input  rounds_in,
    output out_valid,
    input  out_ready,
    output new_a,
    output out_ovf
  );
endinterface

// File: rtl/mont_reduce_iter.sv
// Iterative Montgomery reduction: one radix digit retired per cycle,
// then a final conditional subtraction and an overflow flag.
module mont_reduce_iter #(
  parameter int SIZE   = 3072,
  parameter int RADIX  = 78,
  parameter int ROUNDS = 40,
  parameter int RW     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mont_reduce_iter_if.slave bus
);

  localparam int AW   = SIZE + RADIX * ROUNDS;
  localparam int ACCW = AW + 1;
  localparam int SW   = ACCW + 1;
  localparam int GW   = SIZE + RADIX;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nxt;

  logic [ACCW-1:0]  r_acc;
  logic [SIZE-1:0]  r_m;
  logic [RADIX-1:0] r_mp;
  logic [RW-1:0]    r_rc;
  logic [RW-1:0]    r_rt;
  logic [SIZE-1:0]  r_new_a;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [RW-1:0]    w_rt;
  logic [RADIX-1:0] w_gamma;
  logic [GW-1:0]    w_gm;
  logic [SW-1:0]    w_sum;
  logic [ACCW-1:0]  w_next;
  logic [ACCW-1:0]  w_diff;
  logic             w_ge_m;
  logic             w_ge_2m;

  assign w_accept = bus.in_valid && (r_state == IDLE);

  // Zero or oversize round requests fall back to the full count.
  assign w_rt = (bus.rounds_in == '0 ||
                 bus.rounds_in > RW'(ROUNDS))
              ? RW'(ROUNDS) : bus.rounds_in;

  assign w_last = (r_rc == r_rt - RW'(1));

  // Digit quotient: low digit of acc times -m^-1, kept mod 2^RADIX.
  assign w_gamma = r_acc[RADIX-1:0] * r_mp;
  assign w_gm    = GW'(w_gamma) * GW'(r_m);

  // Sum carries one spare bit so the add never wraps before the shift.
  assign w_sum  = SW'(r_acc) + SW'(w_gm);
  assign w_next = ACCW'(w_sum >> RADIX);

  assign w_diff  = r_acc - ACCW'(r_m);
  assign w_ge_m  = r_acc >= ACCW'(r_m);
  assign w_ge_2m = r_acc >= ACCW'({r_m, 1'b0});

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.new_a     = r_new_a;
  assign bus.out_ovf   = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_nxt = ROUND;
      ROUND:   if (w_last) w_nxt = FINAL;
      FINAL:   w_nxt = DONE;
      DONE:    if (bus.out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, reduce per round, settle result in FINAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_m     <= '0;
      r_mp    <= '0;
      r_rc    <= '0;
      r_rt    <= '0;
      r_new_a <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc <= ACCW'(bus.a);
            r_m   <= bus.m;
            r_mp  <= bus.m_prime;
            r_rt  <= w_rt;
            r_rc  <= '0;
          end
        end
        ROUND: begin
          r_acc <= w_next;
          r_rc  <= r_rc + RW'(1);
        end
        FINAL: begin
          r_new_a <= w_ge_m ? w_diff[SIZE-1:0]
                            : r_acc[SIZE-1:0];
          r_ovf   <= w_ge_2m;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_reduce_iter.sv
// Bench for mont_reduce_iter: directed cases plus randomized
// operands against a closed-form Montgomery reference model.
module tb_mont_reduce_iter;

  localparam int SIZE   = 8;
  localparam int RADIX  = 4;
  localparam int ROUNDS = 2;
  localparam int RW     = 2;
  localparam int AW     = SIZE + RADIX * ROUNDS;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  longint trace [8];

  always #5 clk = ~clk;

  mont_reduce_iter_if #(
    .SIZE(SIZE), .RADIX(RADIX), .ROUNDS(ROUNDS), .RW(RW)
  ) bus ();

  mont_reduce_iter #(
    .SIZE(SIZE), .RADIX(RADIX), .ROUNDS(ROUNDS), .RW(RW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // -m^-1 mod 2^RADIX, found by search.
  function automatic int mp_digit(input int m);
    int x;
    mp_digit = 0;
    for (x = 0; x < (1 << RADIX); x++)
      if (((m * x + 1) % (1 << RADIX)) == 0) mp_digit = x;
  endfunction

  // Whole-operand Montgomery: acc = (a + q*m)/R, q = -a*m^-1 mod R.
  function automatic void model(input longint a, input int m,
                                input int rin, output longint na,
                                output logic ov, output int r);
    longint rr;
    longint mpr;
    longint q;
    longint acc;
    r = (rin == 0 || rin > ROUNDS) ? ROUNDS : rin;
    rr = 1;
    rr = rr << (RADIX * r);
    mpr = 0;
    for (longint x = 0; x < rr; x++)
      if (((m * x + 1) % rr) == 0) mpr = x;
    q = (a * mpr) % rr;
    acc = (a + q * m) / rr;
    na = (acc >= m) ? ((acc - m) & 255) : (acc & 255);
    ov = (acc >= 2 * m);
  endfunction

  task automatic run_op(input longint a, input int m, input int mp,
                        input int rin, output int lat,
                        output longint na, output logic ov);
    bus.a         = AW'(a);
    bus.m         = SIZE'(m);
    bus.m_prime   = RADIX'(mp);
    bus.rounds_in = RW'(rin);
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.a         = AW'($urandom);
    bus.m         = SIZE'($urandom);
    bus.m_prime   = RADIX'($urandom);
    bus.rounds_in = RW'($urandom);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n <= 8) trace[n-1] = longint'(dut.r_acc);
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    na = longint'(bus.new_a);
    ov = bus.out_ovf;
    if (bus.out_ready && lat != 99) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.m         = '0;
    bus.m_prime   = '0;
    bus.rounds_in = '0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.new_a !== 8'd0) begin
      errors++;
      $display("FAIL reset_new_a: got %0d want 0", bus.new_a);
    end
    checks++;
    if (bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", bus.out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    longint na;
    logic ov;
    run_op(1, 13, 11, 2, lat, na, ov);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    checks++;
    if (trace[0] !== 64'd9) begin
      errors++;
      $display("FAIL basic_acc_r1: got %0d want 9", trace[0]);
    end
    checks++;
    if (trace[1] !== 64'd3) begin
      errors++;
      $display("FAIL basic_acc_r2: got %0d want 3", trace[1]);
    end
    checks++;
    if (na !== 64'd3 || ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got %0d/%b want 3/0", na, ov);
    end
  endtask

  task automatic test_subtract();
    int lat;
    longint na;
    logic ov;
    run_op(3327, 13, 11, 0, lat, na, ov);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL sub_latency: got %0d want 3", lat);
    end
    checks++;
    if (trace[0] !== 64'd212 || trace[1] !== 64'd23) begin
      errors++;
      $display("FAIL sub_acc: got %0d,%0d want 212,23",
               trace[0], trace[1]);
    end
    checks++;
    if (na !== 64'd10 || ov !== 1'b0) begin
      errors++;
      $display("FAIL sub_result: got %0d/%b want 10/0", na, ov);
    end
  endtask

  task automatic test_reduced_rounds();
    int lat;
    longint na;
    logic ov;
    run_op(1, 13, 11, 1, lat, na, ov);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL r1_latency: got %0d want 2", lat);
    end
    checks++;
    if (na !== 64'd9 || ov !== 1'b0) begin
      errors++;
      $display("FAIL r1_result: got %0d/%b want 9/0", na, ov);
    end
  endtask

  task automatic test_overflow();
    int lat;
    longint na;
    logic ov;
    run_op(65535, 13, 11, 2, lat, na, ov);
    checks++;
    if (trace[0] !== 64'd4100 || trace[1] !== 64'd266) begin
      errors++;
      $display("FAIL ovf_acc: got %0d,%0d want 4100,266",
               trace[0], trace[1]);
    end
    checks++;
    if (na !== 64'd253 || ov !== 1'b1) begin
      errors++;
      $display("FAIL ovf_result: got %0d/%b want 253/1", na, ov);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    longint na;
    logic ov;
    bus.out_ready = 1'b0;
    run_op(3327, 13, 11, 0, lat, na, ov);
    checks++;
    if (lat !== 3 || na !== 64'd10) begin
      errors++;
      $display("FAIL bp_first: got lat %0d val %0d want 3/10", lat, na);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.new_a !== 8'd10 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: got %0d rdy %b vld %b want 10/0/1",
                 bus.new_a, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld %b rdy %b want 0/1",
               bus.out_valid, bus.in_ready);
    end
    run_op(1, 13, 11, 2, lat, na, ov);
    checks++;
    if (lat !== 3 || na !== 64'd3 || ov !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got lat %0d val %0d ovf %b want 3/3/0",
               lat, na, ov);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    longint na;
    logic ov;
    bus.a         = AW'(3327);
    bus.m         = SIZE'(13);
    bus.m_prime   = RADIX'(11);
    bus.rounds_in = '0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.new_a !== 8'd0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got rdy %b vld %b val %0d ovf %b",
               bus.in_ready, bus.out_valid, bus.new_a, bus.out_ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL midrst_stale: got vld %b rdy %b want 0/1",
                 bus.out_valid, bus.in_ready);
      end
    end
    run_op(1, 13, 11, 2, lat, na, ov);
    checks++;
    if (lat !== 3 || na !== 64'd3 || ov !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rerun: got lat %0d val %0d ovf %b want 3/3/0",
               lat, na, ov);
    end
  endtask

  task automatic test_random();
    int lat;
    int r;
    int m;
    int mp;
    int rin;
    int stall;
    longint a;
    longint na;
    longint exp_na;
    logic ov;
    logic exp_ov;
    for (int i = 0; i < 40; i++) begin
      m     = $urandom_range(0, 127) * 2 + 1;
      mp    = mp_digit(m);
      rin   = $urandom_range(0, 3);
      a     = longint'($urandom_range(0, 65535));
      stall = $urandom_range(0, 3);
      model(a, m, rin, exp_na, exp_ov, r);
      bus.out_ready = (stall == 0);
      run_op(a, m, mp, rin, lat, na, ov);
      if (stall != 0) begin
        repeat (stall) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || longint'(bus.new_a) !== exp_na) begin
          errors++;
          $display("FAIL rnd_hold %0d: got vld %b val %0d want 1/%0d",
                   i, bus.out_valid, bus.new_a, exp_na);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
      end
      checks++;
      if (lat !== r + 1) begin
        errors++;
        $display("FAIL rnd_latency %0d: got %0d want %0d", i, lat, r + 1);
      end
      checks++;
      if (na !== exp_na || ov !== exp_ov) begin
        errors++;
        $display("FAIL rnd_result %0d: a=%0d m=%0d r=%0d got %0d/%b want %0d/%b",
                 i, a, m, r, na, ov, exp_na, exp_ov);
      end
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subtract();
    test_reduced_rounds();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
